// File: rtl/user_keys_debouncer.sv
// user_keys_debouncer: synchronise, debounce and edge-detect the active-low user keys
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-low reset
//   key_raw        raw asynchronous key pins, 0 = pressed
//   key_db         debounced keys, 0 = pressed
//   press_pulse    one-cycle pulse per key on an accepted 1->0 of key_db
//   release_pulse  one-cycle pulse per key on an accepted 0->1 of key_db
// Optional feature macro USER_KEYS_IRQ_EN adds:
//   flag_clr       write-1-to-clear of press flags
//   press_flag     sticky press flags (set wins over clear)
//   irq            registered OR of the next press_flag value
module user_keys_debouncer #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 250000,
  parameter int CNT_W   = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_db,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
`ifdef USER_KEYS_IRQ_EN
  ,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] press_flag,
  output logic             irq
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
  logic [WIDTH-1:0] s1_q, s2_q, db_q, db_d, press_q, press_d, release_q, release_d, acc;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  // A key is accepted once its synchronised level has disagreed with key_db for CNT_MAX
  // consecutive edges; any agreement restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    logic diff;
    assign diff     = s2_q[i] != db_q[i];
    assign acc[i]   = diff && cnt_q[i] == LAST;
    assign cnt_d[i] = diff && !acc[i] ? cnt_q[i] + 1'b1 : '0;
  end
  assign db_d      = db_q ^ acc;
  assign press_d   = acc & ~s2_q;
  assign release_d = acc & s2_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      db_q      <= '1;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      s1_q      <= key_raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end
  assign key_db        = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`ifdef USER_KEYS_IRQ_EN
  logic [WIDTH-1:0] flag_q, flag_d;
  logic             irq_q;
  // Flags follow the registered press pulse, so irq rises the cycle after press_pulse.
  assign flag_d = press_q | (flag_q & ~flag_clr);
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= |flag_d;
    end
  end
  assign press_flag = flag_q;
  assign irq        = irq_q;
`endif
endmodule

// File: tb/tb_user_keys_debouncer.sv
// tb_user_keys_debouncer: scoreboard bench for user_keys_debouncer with a window-based reference model
module tb_user_keys_debouncer;
  localparam int W  = 8;
  localparam int CM = 4;
  typedef struct {
    logic [W-1:0] db;
    logic [W-1:0] pp;
    logic [W-1:0] rp;
    logic [W-1:0] fl;
    logic         irq;
  } exp_t;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] key_raw = '0;
  logic [W-1:0] flag_clr = '0;
  logic [W-1:0] key_db, press_pulse, release_pulse;
`ifdef USER_KEYS_IRQ_EN
  logic [W-1:0] press_flag;
  logic         irq;
`endif
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  user_keys_debouncer #(.WIDTH(W), .CNT_MAX(CM), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key_db(key_db),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`ifdef USER_KEYS_IRQ_EN
    ,
    .flag_clr(flag_clr),
    .press_flag(press_flag),
    .irq(irq)
`endif
  );
  // Reference model: a key is accepted when the last CM synchronised samples taken since
  // reset all differ from the accepted level. Samples reach the comparison two edges late.
  logic [W-1:0] m_p1 = '1, m_p2 = '1, m_db = '1, m_pp = '0, m_fl = '0, m_acc;
  logic [W-1:0] hist[$];
  exp_t m_e;
  always @(posedge clk) begin
    if (!reset) begin
      hist.delete();
      m_p1 = '1;
      m_p2 = '1;
      m_db = '1;
      m_pp = '0;
      m_fl = '0;
      m_e.pp = '0;
      m_e.rp = '0;
    end else begin
      hist.push_back(m_p2);
      if (hist.size() > CM) void'(hist.pop_front());
      m_acc = '0;
      if (hist.size() == CM)
        for (int k = 0; k < W; k++) begin
          m_acc[k] = 1'b1;
          foreach (hist[j]) if (hist[j][k] == m_db[k]) m_acc[k] = 1'b0;
        end
      m_fl = m_pp | (m_fl & ~flag_clr);
      m_e.pp = m_acc & ~m_p2;
      m_e.rp = m_acc & m_p2;
      m_db = m_db ^ m_acc;
      m_pp = m_e.pp;
      m_p2 = m_p1;
      m_p1 = key_raw;
    end
    m_e.db = m_db;
    m_e.fl = m_fl;
    m_e.irq = |m_fl;
    sb.push_back(m_e);
  end
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("key_db", key_db, mon_e.db);
      chk("press_pulse", press_pulse, mon_e.pp);
      chk("release_pulse", release_pulse, mon_e.rp);
      chk("pulse_overlap", press_pulse & release_pulse, '0);
`ifdef USER_KEYS_IRQ_EN
      chk("press_flag", press_flag, mon_e.fl);
      chk("irq", {7'd0, irq}, {7'd0, mon_e.irq});
`endif
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b0;
    key_raw = 8'h00;
    cyc(3);
    reset = 1'b1;
    key_raw = 8'hFF;
    cyc(4);
    key_raw = 8'hFE;
    cyc(10);
    key_raw = 8'hFF;
    cyc(10);
    key_raw = 8'hF7;
    cyc(3);
    key_raw = 8'hFF;
    cyc(10);
    foreach (key_raw[b]) begin end
    key_raw = 8'hFE; cyc(1);
    key_raw = 8'hFF; cyc(1);
    key_raw = 8'hFE; cyc(10);
    key_raw = 8'hFF; cyc(10);
    key_raw = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    key_raw = 8'h00;
    cyc(12);
    key_raw = 8'hFF;
    cyc(10);
    key_raw = 8'hFB;
    cyc(10);
    key_raw = 8'hFF;
    cyc(6);
    flag_clr = 8'h04;
    cyc(1);
    flag_clr = 8'h00;
    cyc(6);
    key_raw = 8'hFB;
    cyc(6);
    flag_clr = 8'h04;
    cyc(1);
    flag_clr = 8'h00;
    cyc(4);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < W; k++)
        if ($urandom_range(0, 9) == 0) key_raw[k] = ~key_raw[k];
      reset = $urandom_range(0, 199) != 0;
      flag_clr = $urandom_range(0, 7) == 0 ? W'($urandom) : '0;
      cyc(1);
    end
    reset = 1'b1;
    flag_clr = '0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
